dac8413_readback: RTL and testbench

- Read-side controller for the DAC8413 quad 12-bit parallel DAC. It reads back the four channel input registers over the parallel bus using RW=1 and CS low.
- It captures the 12-bit data and compares each word against the 8-bit values last commanded to the write path.
- It sits beside the DAC8413 write controller. The top level muxes the shared bus pins using a req/gnt handshake.
- Used for periodic health checking of the analog output settings.

---
 rtl/dac8413_pkg.sv | 44 ++++
 rtl/dac8413_wait_cnt.sv | 28 ++
 rtl/dac8413_readback.sv | 184 ++++++++++++++++++
 tb/tb_dac8413_readback.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac8413_pkg.sv
// Shared DAC8413 definitions: bus timing, channel addresses, readback state codes.
package dac8413_pkg;

    localparam int unsigned ADDR_SETUP_NS = 300;
    localparam int unsigned ACCESS_NS     = 500;
    localparam int unsigned HOLD_NS       = 300;

    localparam int unsigned CNT_W = 5;
    localparam int unsigned DB_W  = 12;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned N_CH  = 4;

    localparam logic [1:0] CH0 = 2'b00;
    localparam logic [1:0] CH1 = 2'b01;
    localparam logic [1:0] CH2 = 2'b10;
    localparam logic [1:0] CH3 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_GNT = 3'd1,
        ST_ADDR     = 3'd2,
        ST_ACCESS   = 3'd3,
        ST_HOLD     = 3'd4,
        ST_DONE     = 3'd5
    } rb_state_e;

    typedef struct packed {
        logic       rw;
        logic       cs;
        logic [1:0] addr;
        logic       db_oe;
    } dac_bus_t;

    localparam dac_bus_t BUS_IDLE = '{rw: 1'b1, cs: 1'b1, addr: CH0, db_oe: 1'b0};

    function automatic int unsigned clk_period_ns(input int unsigned freq_hz);
        return 32'd1_000_000_000 / freq_hz;
    endfunction

    function automatic int unsigned ns_to_cycles(input int unsigned ns, input int unsigned freq_hz);
        return ns / clk_period_ns(freq_hz);
    endfunction

endpackage

// File: rtl/dac8413_wait_cnt.sv
// Loadable down-counter; tc_c is high while the count sits at zero.
module dac8413_wait_cnt
    import dac8413_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc_c
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign tc_c = (cnt_q == '0);

endmodule

// File: rtl/dac8413_readback.sv
// DAC8413 readback controller: reads all four input registers over the shared
// parallel bus and flags channels that differ from the last commanded values.
module dac8413_readback
    import dac8413_pkg::*;
#(
    parameter int unsigned clk_freq_hz = 22118400
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_start,
    input  logic [EXP_W-1:0]  exp_db0,
    input  logic [EXP_W-1:0]  exp_db1,
    input  logic [EXP_W-1:0]  exp_db2,
    input  logic [EXP_W-1:0]  exp_db3,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              DAC8413_RW,
    output logic              DAC8413_CS,
    output logic              DAC8413_A1,
    output logic              DAC8413_A0,
    output logic              DAC8413_DB_OE,
    input  logic [DB_W-1:0]   DAC8413_DB_I,
    output logic [DB_W-1:0]   rb_db0,
    output logic [DB_W-1:0]   rb_db1,
    output logic [DB_W-1:0]   rb_db2,
    output logic [DB_W-1:0]   rb_db3,
    output logic [N_CH-1:0]   mismatch,
    output logic              rd_done,
    output logic              busy
);

    localparam int unsigned ADDR_CNT = ns_to_cycles(ADDR_SETUP_NS, clk_freq_hz);
    localparam int unsigned ACC_CNT  = ns_to_cycles(ACCESS_NS, clk_freq_hz);
    localparam int unsigned HOLD_CNT = ns_to_cycles(HOLD_NS, clk_freq_hz);
    localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

    if (ADDR_CNT > CNT_MAX || ACC_CNT > CNT_MAX || HOLD_CNT > CNT_MAX) begin : g_cnt_range
        $error("dac8413_readback: bus wait count exceeds %0d-bit counter", CNT_W);
    end

    rb_state_e              state_q, state_d;
    logic [1:0]             ch_q, ch_d;
    logic                   arm_q;
    dac_bus_t               bus_q, bus_d;
    logic                   busy_d, bus_req_d, rd_done_d;
    logic [N_CH-1:0]        mismatch_d;
    logic [EXP_W-1:0]       exp_q [N_CH];
    logic [EXP_W-1:0]       exp_d [N_CH];
    logic [DB_W-1:0]        rb_q  [N_CH];
    logic [DB_W-1:0]        rb_d  [N_CH];
    logic                   cnt_load_c;
    logic [CNT_W-1:0]       cnt_val_c;
    logic                   cnt_tc_c;

    dac8413_wait_cnt #(.W(CNT_W)) u_wait_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load_c),
        .load_val (cnt_val_c),
        .tc_c     (cnt_tc_c)
    );

    // Next-state and next-output logic; every register has a next value here.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        busy_d     = busy;
        bus_req_d  = bus_req;
        rd_done_d  = 1'b0;
        mismatch_d = mismatch;
        exp_d      = exp_q;
        rb_d       = rb_q;
        bus_d      = bus_q;
        bus_d.rw    = 1'b1;
        bus_d.db_oe = 1'b0;
        cnt_load_c = 1'b0;
        cnt_val_c  = '0;

        case (state_q)
            ST_IDLE: begin
                bus_d.cs = 1'b1;
                if (rd_start && arm_q) begin
                    exp_d     = '{exp_db0, exp_db1, exp_db2, exp_db3};
                    busy_d    = 1'b1;
                    bus_req_d = 1'b1;
                    ch_d      = CH0;
                    state_d   = ST_WAIT_GNT;
                end
            end
            ST_WAIT_GNT: begin
                if (bus_gnt) begin
                    bus_d.addr = ch_q;
                    cnt_load_c = 1'b1;
                    cnt_val_c  = CNT_W'(ADDR_CNT);
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (cnt_tc_c) begin
                    bus_d.cs   = 1'b0;
                    cnt_load_c = 1'b1;
                    cnt_val_c  = CNT_W'(ACC_CNT);
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_tc_c) begin
                    rb_d[ch_q] = DAC8413_DB_I;
                    bus_d.cs   = 1'b1;
                    cnt_load_c = 1'b1;
                    cnt_val_c  = CNT_W'(HOLD_CNT);
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_tc_c) begin
                    if (ch_q == CH3) begin
                        state_d = ST_DONE;
                    end else begin
                        ch_d       = ch_q + 2'd1;
                        bus_d.addr = ch_q + 2'd1;
                        cnt_load_c = 1'b1;
                        cnt_val_c  = CNT_W'(ADDR_CNT);
                        state_d    = ST_ADDR;
                    end
                end
            end
            ST_DONE: begin
                // Compare against the values latched at start, not the live inputs.
                for (int i = 0; i < N_CH; i++) begin
                    mismatch_d[i] = (rb_q[i] != {exp_q[i], 4'h0});
                end
                rd_done_d = 1'b1;
                busy_d    = 1'b0;
                bus_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                bus_d.cs  = 1'b1;
                busy_d    = 1'b0;
                bus_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // arm_q blocks an rd_start seen on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ch_q     <= CH0;
            arm_q    <= 1'b0;
            bus_q    <= BUS_IDLE;
            busy     <= 1'b0;
            bus_req  <= 1'b0;
            rd_done  <= 1'b0;
            mismatch <= '0;
            exp_q    <= '{default: '0};
            rb_q     <= '{default: '0};
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            arm_q    <= 1'b1;
            bus_q    <= bus_d;
            busy     <= busy_d;
            bus_req  <= bus_req_d;
            rd_done  <= rd_done_d;
            mismatch <= mismatch_d;
            exp_q    <= exp_d;
            rb_q     <= rb_d;
        end
    end

    assign DAC8413_RW    = bus_q.rw;
    assign DAC8413_CS    = bus_q.cs;
    assign DAC8413_A1    = bus_q.addr[1];
    assign DAC8413_A0    = bus_q.addr[0];
    assign DAC8413_DB_OE = bus_q.db_oe;
    assign rb_db0        = rb_q[0];
    assign rb_db1        = rb_q[1];
    assign rb_db2        = rb_q[2];
    assign rb_db3        = rb_q[3];

endmodule

// File: tb/tb_dac8413_readback.sv
// Self-checking bench for dac8413_readback with a behavioural DAC8413 read model.
`timescale 1ns/100ps
module tb_dac8413_readback;

    localparam real         HALF   = 22.6;
    localparam int unsigned CLK_HZ = 22118400;
    localparam int unsigned PER_NS = 1000000000 / CLK_HZ;
    localparam int unsigned A_CNT  = 300 / PER_NS;
    localparam int unsigned C_CNT  = 500 / PER_NS;
    localparam int unsigned H_CNT  = 300 / PER_NS;
    localparam int unsigned PER_CH = (A_CNT + 1) + (C_CNT + 1) + (H_CNT + 1);
    localparam int          LAT    = 2 + 4 * PER_CH + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_start = 1'b0;
    logic        bus_gnt = 1'b0;
    logic [7:0]  exp_db  [4];
    logic [7:0]  exp_lat [4];
    logic [11:0] dac_mem [4];
    logic        bus_req, rw, cs, a1, a0, db_oe, rd_done, busy;
    logic [11:0] db_i, rb_db0, rb_db1, rb_db2, rb_db3;
    logic [3:0]  mismatch;
    int          checks = 0;
    int          failures = 0;

    dac8413_readback dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_start      (rd_start),
        .exp_db0       (exp_db[0]),
        .exp_db1       (exp_db[1]),
        .exp_db2       (exp_db[2]),
        .exp_db3       (exp_db[3]),
        .bus_req       (bus_req),
        .bus_gnt       (bus_gnt),
        .DAC8413_RW    (rw),
        .DAC8413_CS    (cs),
        .DAC8413_A1    (a1),
        .DAC8413_A0    (a0),
        .DAC8413_DB_OE (db_oe),
        .DAC8413_DB_I  (db_i),
        .rb_db0        (rb_db0),
        .rb_db1        (rb_db1),
        .rb_db2        (rb_db2),
        .rb_db3        (rb_db3),
        .mismatch      (mismatch),
        .rd_done       (rd_done),
        .busy          (busy)
    );

    always #(HALF) clk = ~clk;

    // DAC drives the selected register only during a read access; junk otherwise.
    assign db_i = (!cs && rw) ? dac_mem[{a1, a0}] : 12'hA5A;

    function automatic logic [3:0] model_mismatch();
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = (dac_mem[i] != {exp_lat[i], 4'h0});
        return m;
    endfunction

    function automatic logic [47:0] model_rb();
        return {dac_mem[3], dac_mem[2], dac_mem[1], dac_mem[0]};
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        exp_lat  = exp_db;
        rd_start = 1'b1;
    endtask

    task automatic wait_done(input int budget, output int first, output int pulses);
        first = -1;
        pulses = 0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            rd_start = 1'b0;
            if (rd_done === 1'b1) begin
                pulses++;
                if (first < 0) first = n;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rw, cs, a1, a0, db_oe} !== 5'b11000) begin
            failures++; $display("FAIL reset_bus got=%b want=11000", {rw, cs, a1, a0, db_oe});
        end
        checks++;
        if ({bus_req, busy, rd_done, mismatch} !== 7'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b want=0000000", {bus_req, busy, rd_done, mismatch});
        end
        checks++;
        if ({rb_db3, rb_db2, rb_db1, rb_db0} !== 48'h0) begin
            failures++; $display("FAIL reset_rb got=%h want=0", {rb_db3, rb_db2, rb_db1, rb_db0});
        end
        // rd_start coincident with reset release must be ignored
        rst_n = 1'b1;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, bus_req} !== 2'b00) begin
            failures++; $display("FAIL start_at_release got busy/req=%b want=00", {busy, bus_req});
        end
    endtask

    task automatic test_basic();
        int first, pulses;
        bus_gnt = 1'b1;
        exp_db  = '{8'h80, 8'h40, 8'h20, 8'hFF};
        dac_mem = '{12'h800, 12'h400, 12'h200, 12'hFF0};
        pulse_start();
        wait_done(LAT + 20, first, pulses);
        checks++;
        if (first != LAT || pulses != 1) begin
            failures++; $display("FAIL basic_latency got=%0d pulses=%0d want=%0d pulses=1", first, pulses, LAT);
        end
        checks++;
        if ({rb_db3, rb_db2, rb_db1, rb_db0} !== model_rb()) begin
            failures++; $display("FAIL basic_rb got=%h want=%h", {rb_db3, rb_db2, rb_db1, rb_db0}, model_rb());
        end
        checks++;
        if (mismatch !== 4'b0000) begin
            failures++; $display("FAIL basic_mismatch got=%b want=0000", mismatch);
        end
        checks++;
        if ({busy, bus_req} !== 2'b00) begin
            failures++; $display("FAIL basic_idle got busy/req=%b want=00", {busy, bus_req});
        end
    endtask

    task automatic test_mismatch();
        int first, pulses;
        logic [11:0] ch2_vals [2];
        ch2_vals = '{12'h201, 12'h210};
        for (int k = 0; k < 2; k++) begin
            dac_mem[2] = ch2_vals[k];
            pulse_start();
            wait_done(LAT + 10, first, pulses);
            checks++;
            if (first != LAT || mismatch !== model_mismatch() || mismatch !== 4'b0100) begin
                failures++; $display("FAIL mismatch_ch2_%0d got=%b lat=%0d want=%b lat=%0d",
                                     k, mismatch, first, model_mismatch(), LAT);
            end
            checks++;
            if (rb_db2 !== ch2_vals[k]) begin
                failures++; $display("FAIL mismatch_rb2_%0d got=%h want=%h", k, rb_db2, ch2_vals[k]);
            end
        end
    endtask

    task automatic test_random();
        int first, pulses;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 4; i++) begin
                exp_db[i]  = 8'($urandom);
                dac_mem[i] = ($urandom_range(0, 1) == 1) ? {exp_db[i], 4'h0} : 12'($urandom);
            end
            pulse_start();
            wait_done(LAT + 10, first, pulses);
            checks++;
            if (first != LAT || pulses != 1 || mismatch !== model_mismatch()) begin
                failures++; $display("FAIL random_%0d got mm=%b lat=%0d pulses=%0d want mm=%b lat=%0d",
                                     it, mismatch, first, pulses, model_mismatch(), LAT);
            end
            checks++;
            if ({rb_db3, rb_db2, rb_db1, rb_db0} !== model_rb()) begin
                failures++; $display("FAIL random_rb_%0d got=%h want=%h", it, {rb_db3, rb_db2, rb_db1, rb_db0}, model_rb());
            end
        end
    endtask

    task automatic test_gnt_wait();
        int first, pulses, bad;
        logic [1:0] addr0;
        bus_gnt = 1'b0;
        addr0 = {a1, a0};
        pulse_start();
        bad = 0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            rd_start = 1'b0;
            if (bus_req !== 1'b1 || cs !== 1'b1 || {a1, a0} !== addr0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL gnt_wait_idle got=%0d bad cycles want=0", bad);
        end
        bus_gnt = 1'b1;
        wait_done(LAT + 10, first, pulses);
        checks++;
        if (first != LAT - 1 || pulses != 1 || mismatch !== model_mismatch()) begin
            failures++; $display("FAIL gnt_wait_latency got=%0d mm=%b want=%0d mm=%b",
                                 first, mismatch, LAT - 1, model_mismatch());
        end
    endtask

    task automatic test_timing();
        real t_addr, t_rise, t_fall, min_setup, min_low, min_hold;
        int falls, bus_bad, pulses;
        bit rise_pending;
        logic prev_cs;
        logic [1:0] prev_addr;
        for (int i = 0; i < 4; i++) begin
            exp_db[i]  = 8'($urandom);
            dac_mem[i] = {exp_db[i], 4'h0};
        end
        min_setup = 1.0e9; min_low = 1.0e9; min_hold = 1.0e9;
        falls = 0; bus_bad = 0; pulses = 0; rise_pending = 1'b0;
        t_rise = 0.0; t_fall = 0.0;
        pulse_start();
        t_addr = $realtime;
        prev_cs = cs;
        prev_addr = {a1, a0};
        for (int n = 1; n <= LAT + 5; n++) begin
            @(negedge clk);
            rd_start = 1'b0;
            if (rw !== 1'b1 || db_oe !== 1'b0) bus_bad++;
            if (rd_done === 1'b1) pulses++;
            if ({a1, a0} !== prev_addr) begin
                if (cs !== 1'b1) bus_bad++;
                if (rise_pending && ($realtime - t_rise) < min_hold) min_hold = $realtime - t_rise;
                rise_pending = 1'b0;
                t_addr = $realtime;
                prev_addr = {a1, a0};
            end
            if (prev_cs && !cs) begin
                falls++;
                t_fall = $realtime;
                if (($realtime - t_addr) < min_setup) min_setup = $realtime - t_addr;
            end
            if (!prev_cs && cs) begin
                if (($realtime - t_fall) < min_low) min_low = $realtime - t_fall;
                t_rise = $realtime;
                rise_pending = 1'b1;
            end
            prev_cs = cs;
        end
        checks++;
        if (falls != 4 || pulses != 1) begin
            failures++; $display("FAIL timing_accesses got falls=%0d done=%0d want 4 and 1", falls, pulses);
        end
        checks++;
        if (min_low < 500.0) begin
            failures++; $display("FAIL timing_cs_low got=%0.1f ns want>=500", min_low);
        end
        checks++;
        if (min_setup < 300.0) begin
            failures++; $display("FAIL timing_setup got=%0.1f ns want>=300", min_setup);
        end
        checks++;
        if (min_hold < 300.0) begin
            failures++; $display("FAIL timing_hold got=%0.1f ns want>=300", min_hold);
        end
        checks++;
        if (bus_bad != 0 || mismatch !== 4'b0000) begin
            failures++; $display("FAIL timing_bus got=%0d bad samples mm=%b want=0 mm=0000", bus_bad, mismatch);
        end
    endtask

    task automatic test_busy_ignore();
        int first, pulses;
        logic [3:0]  prev_mm;
        logic [11:0] prev_rb3;
        prev_mm  = model_mismatch();
        prev_rb3 = dac_mem[3];
        for (int i = 0; i < 4; i++) begin
            exp_db[i]  = 8'($urandom);
            dac_mem[i] = {exp_db[i], 4'h0};
        end
        dac_mem[3] = ~prev_rb3;
        pulse_start();
        first = -1;
        pulses = 0;
        for (int n = 1; n <= LAT + 20; n++) begin
            @(negedge clk);
            rd_start = 1'b0;
            if (n == 30) begin
                checks++;
                if (mismatch !== prev_mm || rb_db3 !== prev_rb3) begin
                    failures++; $display("FAIL busy_hold_prev got mm=%b rb3=%h want mm=%b rb3=%h",
                                         mismatch, rb_db3, prev_mm, prev_rb3);
                end
                for (int i = 0; i < 4; i++) exp_db[i] = ~exp_db[i];
                rd_start = 1'b1;
            end
            if (rd_done === 1'b1) begin
                pulses++;
                if (first < 0) first = n;
            end
        end
        checks++;
        if (first != LAT || pulses != 1) begin
            failures++; $display("FAIL busy_restart got lat=%0d pulses=%0d want lat=%0d pulses=1", first, pulses, LAT);
        end
        checks++;
        if (mismatch !== model_mismatch() || busy !== 1'b0) begin
            failures++; $display("FAIL busy_latched_exp got mm=%b busy=%b want mm=%b busy=0",
                                 mismatch, busy, model_mismatch());
        end
    endtask

    task automatic test_reset_mid();
        int first, pulses, n, spurious;
        bit found;
        for (int i = 0; i < 4; i++) begin
            exp_db[i]  = 8'($urandom);
            dac_mem[i] = 12'($urandom);
        end
        pulse_start();
        found = 1'b0;
        n = 0;
        while (!found && n < LAT) begin
            @(negedge clk);
            rd_start = 1'b0;
            n++;
            if (cs === 1'b0 && {a1, a0} === 2'b01) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL reset_mid_reach got=timeout want=channel 1 access");
        end
        #5 rst_n = 1'b0;
        #1;
        checks++;
        if ({cs, bus_req, busy, rd_done} !== 4'b1000 || mismatch !== 4'b0) begin
            failures++; $display("FAIL reset_mid_ctrl got cs/req/busy/done=%b mm=%b want=1000 mm=0000",
                                 {cs, bus_req, busy, rd_done}, mismatch);
        end
        checks++;
        if ({rb_db3, rb_db2, rb_db1, rb_db0} !== 48'h0) begin
            failures++; $display("FAIL reset_mid_rb got=%h want=0", {rb_db3, rb_db2, rb_db1, rb_db0});
        end
        spurious = 0;
        repeat (3) begin
            @(negedge clk);
            if (rd_done !== 1'b0) spurious++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rd_done !== 1'b0 || busy !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++; $display("FAIL reset_mid_quiet got=%0d active cycles want=0", spurious);
        end
        pulse_start();
        wait_done(LAT + 10, first, pulses);
        checks++;
        if (first != LAT || pulses != 1 || mismatch !== model_mismatch()
            || {rb_db3, rb_db2, rb_db1, rb_db0} !== model_rb()) begin
            failures++; $display("FAIL reset_mid_rerun got lat=%0d mm=%b rb=%h want lat=%0d mm=%b rb=%h",
                                 first, mismatch, {rb_db3, rb_db2, rb_db1, rb_db0}, LAT, model_mismatch(), model_rb());
        end
    endtask

    initial begin
        #(2.0 * HALF * 60000);
        $display("FAIL watchdog got=timeout want=bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_db  = '{default: '0};
        exp_lat = '{default: '0};
        dac_mem = '{default: '0};
        test_reset();
        test_basic();
        test_mismatch();
        test_busy_ignore();
        test_gnt_wait();
        test_timing();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
